// File: rtl/store_size_rmw.sv
// Store-size unit: performs sw directly and sh/sb as read-modify-write on word-addressed memory.
// The control unit sequences it with a start/done handshake; err flags misaligned or illegal sizes.
module store_size_rmw (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ss_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] b_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_BAD  = 2'b11
    } storeSizeE;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE,
        ERR
    } stateE;

    stateE     state;
    stateE     nextState;
    storeSizeE reqSize;
    storeSizeE capSize;
    logic [1:0]  capLane;
    logic [15:0] capData;
    logic        accept;
    logic        reqLegal;
    logic [3:0]  byteEn;
    logic [31:0] laneData;
    logic [31:0] mergedWord;
    logic        nextMemWr;
    logic        nextBusy;
    logic        nextDone;
    logic        nextErr;

    assign reqSize = storeSizeE'(ss_ctrl);
    assign accept  = (state == IDLE) && start;

    always_comb begin
        reqLegal = 1'b0;
        case (reqSize)
            SIZE_WORD: reqLegal = (addr[1:0] == 2'b00);
            SIZE_HALF: reqLegal = ~addr[0];
            SIZE_BYTE: reqLegal = 1'b1;
            default:   reqLegal = 1'b0;
        endcase
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!reqLegal)                   nextState = ERR;
                    else if (reqSize == SIZE_WORD)   nextState = WRITE;
                    else                             nextState = READ;
                end
            end
            READ:    nextState = WAIT;
            WAIT:    nextState = WRITE;
            WRITE:   nextState = DONE;
            DONE:    nextState = IDLE;
            ERR:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered, then registered below.
    always_comb begin
        nextMemWr = (nextState == WRITE);
        nextBusy  = (nextState == READ) || (nextState == WAIT) ||
                    (nextState == WRITE) || (nextState == DONE);
        nextDone  = (nextState == DONE);
        nextErr   = (nextState == ERR);
    end

    // Lane merge: replicate the store data across all lanes, then pick per byte.
    always_comb begin
        byteEn     = 4'b0000;
        laneData   = {4{capData[7:0]}};
        mergedWord = mem_rdata;
        if (capSize == SIZE_HALF) begin
            byteEn   = capLane[1] ? 4'b1100 : 4'b0011;
            laneData = {2{capData}};
        end else begin
            byteEn   = 4'b0001 << capLane;
        end
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) mergedWord[8*i +: 8] = laneData[8*i +: 8];
        end
    end

    // NOTE: capture registers carry no reset; they are always written on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            capSize <= reqSize;
            capLane <= addr[1:0];
            capData <= b_data[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_wr <= nextMemWr;
            busy   <= nextBusy;
            done   <= nextDone;
            err    <= nextErr;
            if (accept && reqLegal) begin
                mem_addr <= {addr[31:2], 2'b00};
                if (reqSize == SIZE_WORD) mem_wdata <= b_data;
            end
            if (state == WAIT) mem_wdata <= mergedWord;
        end
    end

endmodule

// File: doc/store_size_rmw.md
# store_size_rmw

Store-size unit for the multicycle MIPS datapath: the write-side counterpart to the load/reduce path that picks a word from MDR or B. It takes register B and a store-size control, and performs sw, sh or sb to word-addressed memory. Sub-word stores use a read-modify-write sequence, so the other bytes of the memory word are preserved. It sits between register B / ALUOut and the memory write port, and the control unit sequences it with a start/done handshake.

## Interface

Parameters:
- none; all widths fixed at 32 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  one-cycle request, sampled only in IDLE
- ss_ctrl  input  2  store size: 00 = sw, 01 = sh, 10 = sb, 11 = illegal
- addr  input  32  byte address (ALUOut)
- b_data  input  32  store data (register B); sh uses [15:0], sb uses [7:0]
- mem_rdata  input  32  memory read data, valid the cycle after mem_addr is presented with mem_wr = 0
- mem_addr  output  32  word-aligned address to memory: {addr[31:2], 2'b00}
- mem_wdata  output  32  merged write word
- mem_wr  output  1  memory write enable, one-cycle pulse
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted (inclusive)
- done  output  1  one-cycle pulse on successful completion
- err  output  1  one-cycle pulse on a misaligned or illegal request; no memory write occurs

## Operation

- Byte ordering is little-endian. Byte lane = addr[1:0] and occupies bits [8*lane+7 : 8*lane]. Halfword lane = addr[1] and occupies bits [16*addr[1]+15 : 16*addr[1]].
- On an accepted start, the block captures addr, b_data and ss_ctrl into internal registers. Later changes on the inputs have no effect until the next accepted start.
- Alignment check:
  - sw with addr[1:0] != 0 is an error.
  - sh with addr[0] = 1 is an error.
  - ss_ctrl = 11 is an error.
  - sb is never misaligned.
- FSM states:
  - IDLE
    - start = 1 and request legal:
      - ss_ctrl = sw → WRITE
      - otherwise → READ
    - start = 1 and request illegal → ERR
    - otherwise stay in IDLE.
  - READ: drive mem_addr with mem_wr = 0 → WAIT.
  - WAIT: latch mem_rdata into the internal merge register → WRITE.
  - WRITE: drive mem_wr = 1 and mem_wdata → DONE.
    - sw: mem_wdata = captured b_data.
    - sh/sb: mem_wdata = latched word with the selected lane replaced by b_data low bits.
  - DONE: done = 1 → IDLE.
  - ERR: err = 1 → IDLE.
- start asserted in any state other than IDLE is ignored. It is not queued.
- mem_wdata is don't-care outside WRITE. It holds its last value.
- reset has priority over every transition. Outputs take their reset values on the clock edge where reset is sampled high, including mid-sequence. An interrupted sub-word store never issues mem_wr.

## Timing

- All outputs are registered. Reset values: mem_addr = 0, mem_wdata = 0, mem_wr = 0, busy = 0, done = 0, err = 0; state = IDLE.
- Cycle 0 is the cycle in which start = 1 is sampled in IDLE.
- sw sequence:
  - cycle 1: mem_wr = 1, busy = 1
  - cycle 2: done = 1, busy = 1
  - cycle 3: idle, and a new start is accepted.
  - Latency to done: 2.
- sh/sb sequence:
  - cycle 1: READ, mem_addr valid
  - cycle 2: WAIT, mem_rdata sampled at the end of this cycle
  - cycle 3: mem_wr = 1
  - cycle 4: done = 1
  - Latency to done: 4.
- Error sequence: cycle 1 has err = 1 with busy = 0, and mem_wr stays 0 throughout.
- mem_addr is stable from cycle 1 through the WRITE cycle.
- Back-to-back: start may be re-asserted in the cycle after done or err, and is accepted there.

## Test plan

- sw: addr = 0x0000_0010, b_data = 0xDEAD_BEEF, start → cycle 1 has mem_wr = 1, mem_addr = 0x10, mem_wdata = 0xDEAD_BEEF; cycle 2 has done = 1; no read cycle.
- sb lane 2: addr = 0x0000_0022, b_data = 0x0000_00AB, memory word = 0x1122_3344 → single write of 0x11AB_3344 to 0x20 in cycle 3; done in cycle 4.
- sh upper: addr = 0x0000_0042, b_data = 0xFFFF_CAFE, memory = 0x1234_5678 → write 0xCAFE_5678 to 0x40; lower half unchanged.
- Misaligned: sh at 0x...1 and sw at 0x...2, each run separately → err = 1 in cycle 1; mem_wr never asserts; busy stays 0; block accepts a new start in cycle 2.
- Reset mid-op: sb start, then reset asserted in the WAIT cycle → next edge returns all outputs to reset values; no mem_wr pulse ever appears; a subsequent sw completes normally.
- Ignored start: re-assert start with different addr during READ → original store completes unchanged; exactly one done pulse.
